// File: rtl/sdram_port_pkg.sv
// Shared types and defaults for the SDRAM FIFO port.
// Holds the FSM encoding, burst/FIFO defaults and the data width.
`include "sdram_timing.v"
package sdram_port_pkg;
    localparam int DW             = `SDRAM_DATA_WIDTH;
    localparam int BURST_LEN_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;
endpackage

// File: rtl/sdram_fifo_port_if.sv
// SDRAM-controller side bundle of the FIFO port.
// master: burst requests, addresses, write data; slave: acks, read data.
interface sdram_fifo_port_if #(
    parameter int ADDR_W = 24
);
    import sdram_port_pkg::*;

    logic              sdram_wr_req;
    logic              sdram_wr_ack;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic [DW-1:0]     sdram_din;
    logic              sdram_rd_req;
    logic              sdram_rd_ack;
    logic [ADDR_W-1:0] sdram_rd_addr;
    logic [DW-1:0]     sdram_dout;

    modport master (
        output sdram_wr_req, sdram_wr_addr, sdram_din,
        output sdram_rd_req, sdram_rd_addr,
        input  sdram_wr_ack, sdram_rd_ack, sdram_dout
    );

    modport slave (
        input  sdram_wr_req, sdram_wr_addr, sdram_din,
        input  sdram_rd_req, sdram_rd_addr,
        output sdram_wr_ack, sdram_rd_ack, sdram_dout
    );
endinterface

// File: rtl/sdram_timing.v
// SDRAM controller timing/config macros shared by the port logic.
// Provides SDRAM_DATA_WIDTH, the controller data-bus width.
`ifndef SDRAM_TIMING_V
`define SDRAM_TIMING_V
`define SDRAM_DATA_WIDTH 16
`endif

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, full and empty flags.
// Ports: push_i/din_i write, pop_i read, head_o = oldest word, count_o/full_o/empty_o.
module sync_fifo #(
    parameter int  DW    = 16,
    parameter int  DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Overflow/underflow attempts are ignored here, so callers may strobe freely.
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/sdram_fifo_port.sv
// User FIFO port that streams data through an SDRAM ring buffer in bursts.
// Ports: wr_en/wr_data/wr_full user write, rd_en/rd_data/rd_empty user read,
// sdram_init_done controller ready, sdram (master) burst request/ack bundle.
// Build option: SDRAM_PORT_FWFT_EN makes the read FIFO show-ahead.
module sdram_fifo_port
    import sdram_port_pkg::*;
#(
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = 24,
    parameter int ADDR_MIN   = 0,
    parameter int ADDR_MAX   = 1024
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    output logic [DW-1:0]     rd_data,
    output logic              wr_full,
    output logic              rd_empty,
    input  logic              sdram_init_done,
    sdram_fifo_port_if.master sdram
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(BURST_LEN) + 1;

    localparam logic [FAW:0]    BL_F      = (FAW+1)'(BURST_LEN);
    localparam logic [FAW:0]    DEPTH_F   = (FAW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] BL_L      = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0] REGION    = (ADDR_W+1)'(ADDR_MAX - ADDR_MIN);
    localparam logic [ADDR_W-1:0] A_MIN   = ADDR_W'(ADDR_MIN);
    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(ADDR_MAX - BURST_LEN);
    localparam logic [ADDR_W-1:0] A_STEP  = ADDR_W'(BURST_LEN);
    localparam logic [CW-1:0]   BEAT_LAST = CW'(BURST_LEN - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [1:0]        sync_q;
    logic              init_ok;
    logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              wr_req, rd_req, wr_pop, rd_push;
    logic              burst_ack, burst_end;
    logic [DW-1:0]     wr_head, rd_head;
    logic [FAW:0]      wr_count, rd_count, rd_free;
    logic              wr_empty_unused, rd_full_unused;

    sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk     (clk_50m),
        .rst_n   (rst_n),
        .push_i  (wr_en),
        .din_i   (wr_data),
        .pop_i   (wr_pop),
        .head_o  (wr_head),
        .count_o (wr_count),
        .full_o  (wr_full),
        .empty_o (wr_empty_unused)
    );

    sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk     (clk_50m),
        .rst_n   (rst_n),
        .push_i  (rd_push),
        .din_i   (sdram.sdram_dout),
        .pop_i   (rd_en),
        .head_o  (rd_head),
        .count_o (rd_count),
        .full_o  (rd_full_unused),
        .empty_o (rd_empty)
    );

    assign init_ok   = sync_q[1];
    assign rd_free   = DEPTH_F - rd_count;
    assign burst_ack = wr_pop | rd_push;
    assign burst_end = burst_ack & (beat_q == BEAT_LAST);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write wins over read; a full region blocks further write bursts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (init_ok && wr_count >= BL_F && level_q != REGION)
                    state_d = ST_WRITE;
                else if (init_ok && level_q >= BL_L && rd_free >= BL_F)
                    state_d = ST_READ;
            end
            ST_WRITE, ST_READ: begin
                if (burst_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Acks only count while a burst of the matching direction is open.
    always_comb begin
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_pop  = 1'b0;
        rd_push = 1'b0;
        unique case (state_q)
            ST_WRITE: begin
                wr_req = 1'b1;
                wr_pop = sdram.sdram_wr_ack;
            end
            ST_READ: begin
                rd_req  = 1'b1;
                rd_push = sdram.sdram_rd_ack;
            end
            default: ;
        endcase
    end

    always_comb begin
        beat_d  = burst_ack ? beat_q + CW'(1) : beat_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        level_d = level_q;
        if (burst_end) begin
            beat_d = '0;
            if (state_q == ST_WRITE) begin
                waddr_d = (waddr_q == A_LAST) ? A_MIN : waddr_q + A_STEP;
                level_d = level_q + BL_L;
            end else begin
                raddr_d = (raddr_q == A_LAST) ? A_MIN : raddr_q + A_STEP;
                level_d = level_q - BL_L;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            beat_q  <= '0;
            waddr_q <= A_MIN;
            raddr_q <= A_MIN;
            level_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], sdram_init_done};
            beat_q  <= beat_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            level_q <= level_d;
        end
    end

    assign sdram.sdram_wr_req  = wr_req;
    assign sdram.sdram_rd_req  = rd_req;
    assign sdram.sdram_wr_addr = waddr_q;
    assign sdram.sdram_rd_addr = raddr_q;
    assign sdram.sdram_din     = wr_req ? wr_head : '0;

`ifdef SDRAM_PORT_FWFT_EN
    assign rd_data = rd_empty ? '0 : rd_head;
`else
    logic [DW-1:0] rd_data_q;
    logic          rd_pop;

    assign rd_pop = rd_en & ~rd_empty;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_pop) begin
            rd_data_q <= rd_head;
        end
    end

    assign rd_data = rd_data_q;
`endif
endmodule

// File: doc/sdram_fifo_port.md
SDRAM_FIFO_PORT -- requirements
Module: sdram_fifo_port

Interface
REQ-001 Parameter BURST_LEN, 8, words per SDRAM burst; SHALL be a power of two, 1 to 256.
REQ-002 Parameter FIFO_DEPTH, 64, words per internal FIFO; SHALL be a power of two and at least 2*BURST_LEN.
REQ-003 Parameter ADDR_W, 24, SDRAM word-address width.
REQ-004 Parameter ADDR_MIN, 0, first word address of the buffer region.
REQ-005 Parameter ADDR_MAX, 1024, exclusive end of the region; (ADDR_MAX-ADDR_MIN) SHALL be a multiple of BURST_LEN.
REQ-006 Ports SHALL be: clk_50m in 1 clock; rst_n in 1 async active-low reset; wr_en in 1 user write strobe; wr_data in `SDRAM_DATA_WIDTH user write word; rd_en in 1 user read strobe; rd_data out `SDRAM_DATA_WIDTH user read word; wr_full out 1 write FIFO full; rd_empty out 1 read FIFO empty; sdram_init_done in 1 controller init complete; sdram_wr_req out 1 write burst request; sdram_wr_ack in 1 per-word write strobe; sdram_wr_addr out ADDR_W burst start address; sdram_din out `SDRAM_DATA_WIDTH word to controller; sdram_rd_req out 1 read burst request; sdram_rd_ack in 1 per-word read strobe; sdram_rd_addr out ADDR_W burst start address; sdram_dout in `SDRAM_DATA_WIDTH word from controller.
REQ-007 Single clock domain clk_50m; reset asynchronous, active-low, on rst_n.

Function
REQ-008 sdram_init_done SHALL pass through a two-flop synchronizer; no request asserts until the synchronized value is 1.
REQ-009 wr_en with wr_full=0 SHALL push wr_data the same edge; wr_en with wr_full=1 SHALL drop the word, with no other state change.
REQ-010 FSM states: IDLE, WRITE, READ. IDLE->WRITE when write-FIFO count >= BURST_LEN; else IDLE->READ when sdram_level >= BURST_LEN and read-FIFO free space >= BURST_LEN; write has priority when both hold.
REQ-011 In WRITE, sdram_wr_req SHALL stay high and sdram_din SHALL present the write-FIFO head; each sdram_wr_ack cycle pops one word; after the BURST_LEN-th ack, req drops the next cycle and the FSM returns to IDLE.
REQ-012 In READ, sdram_rd_req SHALL stay high; each sdram_rd_ack cycle pushes sdram_dout into the read FIFO; after the BURST_LEN-th ack, return to IDLE.
REQ-013 sdram_wr_addr and sdram_rd_addr SHALL each advance by BURST_LEN at burst completion and wrap from ADDR_MAX-BURST_LEN to ADDR_MIN.
REQ-014 sdram_level (ADDR_W+1 bits) SHALL add BURST_LEN on write-burst completion and subtract BURST_LEN on read-burst completion; it never exceeds ADDR_MAX-ADDR_MIN. While sdram_level equals the region size, IDLE->WRITE is blocked.
REQ-015 Standard mode: rd_en with rd_empty=0 SHALL pop, with rd_data valid on the following cycle; rd_en with rd_empty=1 SHALL leave rd_data unchanged.
REQ-016 An ack while the FSM is in IDLE SHALL be ignored.
REQ-017 A simultaneous user push or pop with a burst-side pop or push on the same FIFO SHALL update its count correctly (net change 0).

Reset
REQ-018 Reset SHALL clear both FIFOs, sdram_level, and the synchronizer, and return the FSM to IDLE. Outputs: wr_full=0, rd_empty=1, rd_data=0, sdram_din=0, both req=0, both addr=ADDR_MIN.
REQ-019 Reset asserted mid-burst SHALL abort the burst immediately; the partial burst is discarded.

Configuration
REQ-020 Macro SDRAM_PORT_FWFT_EN defined: the read FIFO is show-ahead. rd_data equals the head word whenever rd_empty=0, and rd_en advances to the next word. Undefined: REQ-015 applies.

Structure
REQ-021 The FSM state encoding and the BURST_LEN and FIFO_DEPTH defaults SHALL live in shared package sdram_port_pkg; the data width comes from `SDRAM_DATA_WIDTH in sdram_timing.v.
REQ-022 Both FIFOs SHALL be instances of one sub-module, sync_fifo, providing count, full and empty outputs.

Verification
REQ-023 Write 1..1024 consecutively, then read 1024 words (ADDR_MAX=1024) -> rd_data sequence is 1..1024, with exactly 128 write and 128 read bursts.
REQ-024 Hold sdram_init_done=0 and write 8 words -> no req; raise init_done -> sdram_wr_req rises 3 cycles later at address 0.
REQ-025 Write 64 words with ack held 0, then write one more -> wr_full=1 and word 65 is dropped; subsequent readback returns 1..64.
REQ-026 Write 1536 words with reads interleaved (ADDR_MAX=1024) -> addresses wrap 1016->0, and data is still in order.
REQ-027 Assert rst_n low after the 3rd ack of a write burst -> req=0 and addr=0 next cycle; post-reset traffic is correct.
REQ-028 With SDRAM_PORT_FWFT_EN, 8 words stored -> rd_data=1 before any rd_en; without the macro, rd_data=1 one cycle after the first rd_en.
